// File: rtl/rule_eval_pkg.sv
// -----------------------------------------------------------------------------
// rule_eval_pkg
// Shared types for the rule evaluation sequencer.
//   rule_t  : operation select carried on in_rule (RULE_SUM .. RULE_ZERO)
//   state_t : sequencer FSM states (IDLE -> SORT -> CALC -> HOLD)
// Optional feature macro used by the top: RULE_EVAL_COUNT_EN
// -----------------------------------------------------------------------------
package rule_eval_pkg;

    typedef enum logic [2:0] {
        RULE_SUM       = 3'd0,
        RULE_RANGE     = 3'd1,
        RULE_MEDIAN    = 3'd2,
        RULE_ALT_SUM   = 3'd3,
        RULE_TOP2_MIN  = 3'd4,
        RULE_NEG_SUM   = 3'd5,
        RULE_NEG_RANGE = 3'd6,
        RULE_ZERO      = 3'd7
    } rule_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_CALC = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/oe_sort_pass.sv
// -----------------------------------------------------------------------------
// oe_sort_pass
// One compare-exchange pass of an odd-even transposition sort (ascending).
//   vec_in  : N_OPS packed unsigned elements, element i at [i*OP_W +: OP_W]
//   odd     : 0 = compare pairs (0,1),(2,3)..., 1 = compare pairs (1,2),(3,4)...
//   vec_out : vec_in after the pass
// Purely combinational; the sequencer feeds the result back for N_OPS cycles.
// -----------------------------------------------------------------------------
module oe_sort_pass #(
    parameter int N_OPS = 6,
    parameter int OP_W  = 4
) (
    input  logic [N_OPS*OP_W-1:0] vec_in,
    input  logic                  odd,
    output logic [N_OPS*OP_W-1:0] vec_out
);

    logic [OP_W-1:0] lo_el;
    logic [OP_W-1:0] hi_el;

    // Pairs in one pass are disjoint, so every pair can be judged from vec_in
    // directly; the pair parity selects which neighbours are compared.
    always_comb begin
        vec_out = vec_in;
        lo_el   = '0;
        hi_el   = '0;
        for (int i = 0; i < N_OPS - 1; i++) begin
            if (((i % 2) == 1) == odd) begin
                lo_el = vec_in[i*OP_W +: OP_W];
                hi_el = vec_in[(i+1)*OP_W +: OP_W];
                if (lo_el > hi_el) begin
                    vec_out[i*OP_W +: OP_W]     = hi_el;
                    vec_out[(i+1)*OP_W +: OP_W] = lo_el;
                end
            end
        end
    end

endmodule

// File: rtl/rule_eval_seq.sv
// -----------------------------------------------------------------------------
// rule_eval_seq
// Accepts a bundle of N_OPS unsigned operands plus a rule, sorts a copy over
// N_OPS cycles, evaluates the rule in one cycle and holds the signed result
// until the consumer takes it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake (in_ready only in IDLE)
//   in_op, in_rule      : packed operands (operand i at [i*OP_W +: OP_W]), rule
//   out_valid/out_ready : output handshake
//   out                 : signed OUT_W-bit result, held while out_valid is low
//   done_cnt            : completed output handshakes (only with
//                         RULE_EVAL_COUNT_EN defined)
// -----------------------------------------------------------------------------
module rule_eval_seq
    import rule_eval_pkg::*;
#(
    parameter  int N_OPS = 6,
    parameter  int OP_W  = 4,
    localparam int OUT_W = OP_W + $clog2(N_OPS) + 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_OPS*OP_W-1:0]    in_op,
    input  logic [2:0]               in_rule,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out
`ifdef RULE_EVAL_COUNT_EN
    ,
    output logic [15:0]              done_cnt
`endif
);

    localparam int CNT_W = $clog2(N_OPS);

    state_t                  state;
    rule_t                   rule_q;
    logic [CNT_W-1:0]        sort_cnt;
    logic [N_OPS*OP_W-1:0]   sort_vec;
    logic [N_OPS*OP_W-1:0]   raw_vec;
    logic [N_OPS*OP_W-1:0]   pass_vec;

    logic signed [OUT_W-1:0] sum_all;
    logic signed [OUT_W-1:0] sum_even;
    logic signed [OUT_W-1:0] sum_odd;
    logic signed [OUT_W-1:0] s_lo;
    logic signed [OUT_W-1:0] s_hi;
    logic signed [OUT_W-1:0] s_hi2;
    logic signed [OUT_W-1:0] s_mid;
    logic signed [OUT_W-1:0] result;

    // A single pass instance is reused every SORT cycle; the count's LSB
    // alternates between even and odd pairs.
    oe_sort_pass #(
        .N_OPS (N_OPS),
        .OP_W  (OP_W)
    ) u_pass (
        .vec_in  (sort_vec),
        .odd     (sort_cnt[0]),
        .vec_out (pass_vec)
    );

    // Order statistics read straight from the sorted register, zero-extended.
    assign s_lo  = OUT_W'(sort_vec[0 +: OP_W]);
    assign s_hi  = OUT_W'(sort_vec[(N_OPS-1)*OP_W +: OP_W]);
    assign s_hi2 = OUT_W'(sort_vec[(N_OPS-2)*OP_W +: OP_W]);
    assign s_mid = OUT_W'(sort_vec[(N_OPS/2)*OP_W +: OP_W]);

    // Sums: the total is order independent, while the alternating sum must
    // use the unsorted copy because index parity refers to arrival order.
    always_comb begin
        sum_all  = '0;
        sum_even = '0;
        sum_odd  = '0;
        for (int i = 0; i < N_OPS; i++) begin
            sum_all = sum_all + OUT_W'(sort_vec[i*OP_W +: OP_W]);
            if ((i % 2) == 0) begin
                sum_even = sum_even + OUT_W'(raw_vec[i*OP_W +: OP_W]);
            end else begin
                sum_odd = sum_odd + OUT_W'(raw_vec[i*OP_W +: OP_W]);
            end
        end
    end

    // Rule evaluation; OUT_W leaves headroom so no case can overflow.
    always_comb begin
        result = '0;
        case (rule_q)
            RULE_SUM:       result = sum_all;
            RULE_RANGE:     result = s_hi - s_lo;
            RULE_MEDIAN:    result = s_mid;
            RULE_ALT_SUM:   result = sum_even - sum_odd;
            RULE_TOP2_MIN:  result = s_hi + s_hi2 - s_lo;
            RULE_NEG_SUM:   result = -sum_all;
            RULE_NEG_RANGE: result = s_lo - s_hi;
            default:        result = '0;
        endcase
    end

    // Sequencer: IDLE captures a transaction, SORT runs exactly N_OPS passes,
    // CALC registers the result, HOLD waits for the consumer. All outputs are
    // registered; out is only written in CALC so it keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rule_q    <= RULE_SUM;
            sort_cnt  <= '0;
            sort_vec  <= '0;
            raw_vec   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
`ifdef RULE_EVAL_COUNT_EN
            done_cnt  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sort_vec <= in_op;
                        raw_vec  <= in_op;
                        rule_q   <= rule_t'(in_rule);
                        sort_cnt <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    sort_vec <= pass_vec;
                    if (sort_cnt == CNT_W'(N_OPS - 1)) begin
                        sort_cnt <= '0;
                        state    <= ST_CALC;
                    end else begin
                        sort_cnt <= sort_cnt + 1'b1;
                    end
                end
                ST_CALC: begin
                    out       <= result;
                    out_valid <= 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
`ifdef RULE_EVAL_COUNT_EN
                        done_cnt  <= done_cnt + 16'd1;
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rule_eval_seq.sv
// -----------------------------------------------------------------------------
// tb_rule_eval_seq
// Self-checking bench for rule_eval_seq at N_OPS=6, OP_W=4. A timeline model
// (busy / result-due / handshake) is compared against the DUT on every falling
// edge; directed transactions are also pinned to hand-computed results.
// Honours RULE_EVAL_COUNT_EN for the done_cnt port.
// -----------------------------------------------------------------------------
module tb_rule_eval_seq;

    localparam int N_OPS = 6;
    localparam int OP_W  = 4;
    localparam int OUT_W = OP_W + $clog2(N_OPS) + 3;
    localparam int VEC_W = N_OPS * OP_W;

    logic                    clk       = 1'b0;
    logic                    rst_n     = 1'b0;
    logic                    in_valid  = 1'b0;
    logic                    out_ready = 1'b0;
    logic [VEC_W-1:0]        in_op     = '0;
    logic [2:0]              in_rule   = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out;
`ifdef RULE_EVAL_COUNT_EN
    logic [15:0]             done_cnt;
`endif

    int checks = 0;
    int errors = 0;

    bit     m_busy    = 1'b0;
    bit     m_valid   = 1'b0;
    int     m_age     = 0;
    longint m_pending = 0;
    longint m_last    = 0;
    int     m_done    = 0;

    always #5 clk = ~clk;

    rule_eval_seq #(
        .N_OPS (N_OPS),
        .OP_W  (OP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rule   (in_rule),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef RULE_EVAL_COUNT_EN
        ,
        .done_cnt  (done_cnt)
`endif
    );

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result straight from the rule definitions: plain integer
    // arithmetic on the operand list and a sorted copy of it.
    function automatic longint modelResult(input logic [VEC_W-1:0] ops, input logic [2:0] rule);
        int u[N_OPS];
        int s[N_OPS];
        int t;
        int sum;
        int alt;
        sum = 0;
        alt = 0;
        for (int i = 0; i < N_OPS; i++) begin
            u[i] = int'(ops[i*OP_W +: OP_W]);
            s[i] = u[i];
            sum += u[i];
            alt += ((i % 2) == 0) ? u[i] : -u[i];
        end
        for (int i = 0; i < N_OPS; i++) begin
            for (int j = 0; j < N_OPS - 1 - i; j++) begin
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
            end
        end
        case (rule)
            3'd0:    return longint'(sum);
            3'd1:    return longint'(s[N_OPS-1] - s[0]);
            3'd2:    return longint'(s[N_OPS/2]);
            3'd3:    return longint'(alt);
            3'd4:    return longint'(s[N_OPS-1] + s[N_OPS-2] - s[0]);
            3'd5:    return longint'(-sum);
            3'd6:    return longint'(s[0] - s[N_OPS-1]);
            default: return 0;
        endcase
    endfunction

    function automatic logic [VEC_W-1:0] packOps(input int v[N_OPS]);
        logic [VEC_W-1:0] p;
        p = '0;
        for (int i = 0; i < N_OPS; i++) begin
            p[i*OP_W +: OP_W] = OP_W'(v[i]);
        end
        return p;
    endfunction

    // Timeline model compared on every falling edge. After the accepting edge
    // the result is due N_OPS+1 edges later (the (N_OPS+2)-th cycle after
    // acceptance) and stays until an edge with out_ready high. Then the model
    // predicts what the next rising edge does from the current inputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_age   = 0;
            m_last  = 0;
            m_done  = 0;
            checkOutput("reset_out_valid", longint'(out_valid), 0);
            checkOutput("reset_out", longint'(out), 0);
        end else begin
            checkOutput("in_ready", longint'(in_ready), longint'(!m_busy));
            checkOutput("out_valid", longint'(out_valid), longint'(m_valid));
            checkOutput("out", longint'(out), m_last);
`ifdef RULE_EVAL_COUNT_EN
            checkOutput("done_cnt", longint'(done_cnt), longint'(m_done));
`endif
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy    = 1'b1;
                    m_age     = 0;
                    m_pending = modelResult(in_op, in_rule);
                end
            end else if (!m_valid) begin
                m_age++;
                if (m_age == N_OPS + 1) begin
                    m_valid = 1'b1;
                    m_last  = m_pending;
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
                m_done  = (m_done + 1) % 65536;
            end
        end
    end

    // Drives one transaction from IDLE, optionally with junk on the input side
    // while busy, stalls the consumer for hold_cycles, then completes it.
    task automatic applyStimulus(input string name, input logic [VEC_W-1:0] ops,
                                 input logic [2:0] rule, input int hold_cycles,
                                 input bit noise, output longint result);
        int edges;
        @(posedge clk); #1;
        checkOutput({name, "_ready_idle"}, longint'(in_ready), 1);
        in_valid = 1'b1;
        in_op    = ops;
        in_rule  = rule;
        @(posedge clk); #1;
        in_valid = noise;
        if (noise) begin
            in_op   = VEC_W'($urandom);
            in_rule = 3'($urandom);
        end
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput({name, "_valid_seen"}, longint'(out_valid), 1);
        checkOutput({name, "_latency_edges"}, longint'(edges), N_OPS + 1);
        result = longint'(out);
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk); #1;
            checkOutput({name, "_hold_out"}, longint'(out), result);
            checkOutput({name, "_hold_valid"}, longint'(out_valid), 1);
            checkOutput({name, "_hold_ready"}, longint'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({name, "_post_valid"}, longint'(out_valid), 0);
        checkOutput({name, "_post_ready"}, longint'(in_ready), 1);
        checkOutput({name, "_post_out_kept"}, longint'(out), result);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int     base[N_OPS];
        int     zeros[N_OPS];
        int     fulls[N_OPS];
        longint exp_lit[8];
        longint res;
        logic [VEC_W-1:0] base_vec;

        base     = '{3, 9, 1, 7, 0, 15};
        zeros    = '{0, 0, 0, 0, 0, 0};
        fulls    = '{15, 15, 15, 15, 15, 15};
        exp_lit  = '{35, 15, 7, -27, 24, -35, -15, 0};
        base_vec = packOps(base);

        $display("[TB] reset");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("init_out", longint'(out), 0);
        checkOutput("init_out_valid", longint'(out_valid), 0);
        checkOutput("init_in_ready", longint'(in_ready), 1);
`ifdef RULE_EVAL_COUNT_EN
        checkOutput("init_done_cnt", longint'(done_cnt), 0);
`endif
        rst_n = 1'b1;

        checkOutput("model_pin_sum", modelResult(base_vec, 3'd0), 35);
        checkOutput("model_pin_alt", modelResult(base_vec, 3'd3), -27);

        $display("[TB] directed rules");
        for (int r = 0; r < 8; r++) begin
            applyStimulus($sformatf("rule%0d", r), base_vec, 3'(r),
                          (r == 0) ? 5 : (r % 3), bit'(r % 2), res);
            checkOutput($sformatf("rule%0d_result", r), res, exp_lit[r]);
        end

        $display("[TB] boundary operands");
        applyStimulus("zeros_r6", packOps(zeros), 3'd6, 0, 1'b1, res);
        checkOutput("zeros_r6_result", res, 0);
        applyStimulus("fulls_r3", packOps(fulls), 3'd3, 1, 1'b1, res);
        checkOutput("fulls_r3_result", res, 0);
        applyStimulus("pre_reset", base_vec, 3'd0, 0, 1'b0, res);
        checkOutput("pre_reset_result", res, 35);

        $display("[TB] reset during sort");
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_op    = base_vec;
        in_rule  = 3'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midsort_rst_out_valid", longint'(out_valid), 0);
        checkOutput("midsort_rst_out", longint'(out), 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1;
        checkOutput("midsort_rst_in_ready", longint'(in_ready), 1);
`ifdef RULE_EVAL_COUNT_EN
        checkOutput("midsort_rst_done_cnt", longint'(done_cnt), 0);
`endif
        applyStimulus("fulls_r0", packOps(fulls), 3'd0, 2, 1'b0, res);
        checkOutput("fulls_r0_result", res, 90);
        applyStimulus("after_rst_b", base_vec, 3'd4, 0, 1'b0, res);
        checkOutput("after_rst_b_result", res, 24);
        applyStimulus("after_rst_c", base_vec, 3'd2, 1, 1'b1, res);
        checkOutput("after_rst_c_result", res, 7);
`ifdef RULE_EVAL_COUNT_EN
        checkOutput("done_cnt_three", longint'(done_cnt), 3);
`endif

        $display("[TB] random transactions");
        for (int t = 0; t < 30; t++) begin
            applyStimulus("rand", VEC_W'($urandom), 3'($urandom), int'($urandom_range(0, 3)),
                          bit'($urandom_range(0, 1)), res);
        end

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
